crm_loader: RTL and testbench

- Front-end (diagnostic) loader for the 2K×84 CRAM store.
- Upstream stage of the CRAM storage block. Owns that block's address, write-data and write-enable inputs while selected.
- Accepts 36-bit diagnostic transfers and stages them into an 84-bit microword. Commits the word to CRAM and reads words back in 36-bit chunks.
- Refuses all CRAM access while the EBOX is running.

---
 rtl/crm_loader_if.sv | 12 +
 rtl/crm_loader.sv | 146 ++++++++++++++
 tb/tb_crm_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crm_loader_if.sv
// Front-end diagnostic transfer bundle between a requester (master) and the
// CRAM loader (slave). Bit numbering follows the RTL convention [35:0].
interface crm_loader_if;
  logic        FE_REQ;
  logic [2:0]  FE_FUNC;
  logic [35:0] FE_DATA;
  logic        FE_ACK;
  logic [35:0] FE_RDATA;

  modport master (output FE_REQ, FE_FUNC, FE_DATA, input  FE_ACK, FE_RDATA);
  modport slave  (input  FE_REQ, FE_FUNC, FE_DATA, output FE_ACK, FE_RDATA);
endinterface

// File: rtl/crm_loader.sv
// Diagnostic loader for the 2Kx84 CRAM: stages 36-bit transfers into a microword,
// commits it and reads it back in chunks. CRM_LOADER_VERIFY_EN adds read-after-write verify.
module crm_loader #(
  parameter int unsigned ADR_W  = 11,
  parameter int unsigned WORD_W = 84,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  crm_loader_if.slave       fe,
  input  logic              RUN,
  output logic              CRM_SEL,
  output logic [ADR_W-1:0]  CRM_ADR,
  output logic [WORD_W-1:0] CRM_DIN,
  output logic              CRM_WE,
  input  logic [WORD_W-1:0] CRM_DOUT,
  output logic              ERR,
  output logic              BUSY
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_RDWAIT  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
`ifdef CRM_LOADER_VERIFY_EN
  localparam logic [2:0] S_VRDWAIT = 3'd5;
  localparam logic [2:0] S_VCMP    = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADR_W-1:0]  adr_q,   adr_d;
  logic [WORD_W-1:0] stg_q,   stg_d;
  logic [35:0]       rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [1:0]        sel_q,   sel_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    stg_d   = stg_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fe.FE_REQ) begin
          state_d = S_ACK;
          case (fe.FE_FUNC)
            3'd0: begin
              adr_d = fe.FE_DATA[ADR_W-1:0];
              err_d = 1'b0;
            end
            3'd1: stg_d[83:48] = fe.FE_DATA;
            3'd2: stg_d[47:12] = fe.FE_DATA;
            3'd3: stg_d[11:0]  = fe.FE_DATA[11:0];
            3'd4: begin
              if (RUN) err_d   = 1'b1;
              else     state_d = S_WRITE;
            end
            default: begin
              // low function bits 1/2/3 select chunk 0/1/2
              sel_d = fe.FE_FUNC[1:0];
              if (RUN) err_d   = 1'b1;
              else     state_d = S_RDWAIT;
            end
          endcase
        end
      end
      S_WRITE: begin
`ifdef CRM_LOADER_VERIFY_EN
        state_d = S_VRDWAIT;
`else
        adr_d   = adr_q + ADR_W'(1);
        state_d = S_ACK;
`endif
      end
      S_RDWAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = S_CAPTURE;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      S_CAPTURE: begin
        case (sel_q)
          2'd1:    rdata_d = CRM_DOUT[83:48];
          2'd2:    rdata_d = CRM_DOUT[47:12];
          default: rdata_d = {24'b0, CRM_DOUT[11:0]};
        endcase
        state_d = S_ACK;
      end
`ifdef CRM_LOADER_VERIFY_EN
      S_VRDWAIT: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = S_VCMP;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      S_VCMP: begin
        if (CRM_DOUT != stg_q) err_d = 1'b1;
        adr_d   = adr_q + ADR_W'(1);
        state_d = S_ACK;
      end
`endif
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      stg_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      stg_q   <= stg_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    CRM_SEL = (state_q == S_WRITE) || (state_q == S_RDWAIT) || (state_q == S_CAPTURE);
`ifdef CRM_LOADER_VERIFY_EN
    CRM_SEL = CRM_SEL || (state_q == S_VRDWAIT) || (state_q == S_VCMP);
`endif
  end

  assign CRM_WE      = (state_q == S_WRITE);
  assign CRM_ADR     = adr_q;
  assign CRM_DIN     = stg_q;
  assign ERR         = err_q;
  assign BUSY        = (state_q != S_IDLE);
  assign fe.FE_ACK   = (state_q == S_ACK);
  assign fe.FE_RDATA = rdata_q;

endmodule

// File: tb/tb_crm_loader.sv
// Bench for crm_loader: CRAM memory model, transaction-level reference model,
// per-cycle output compare, directed literal cases and a randomized phase.
module tb_crm_loader;
  localparam int unsigned RD_LAT = 1;
`ifdef CRM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int COMMIT_LAT = VERIFY ? 3 + RD_LAT : 2;
  localparam int READ_LAT   = 2 + RD_LAT;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        RUN = 1'b0;
  logic        CRM_SEL, CRM_WE, ERR, BUSY;
  logic [10:0] CRM_ADR;
  logic [83:0] CRM_DIN, CRM_DOUT;

  always #5 CLK = ~CLK;

  crm_loader_if fe();

  crm_loader #(.ADR_W(11), .WORD_W(84), .RD_LAT(RD_LAT)) dut (
    .CLK(CLK), .nRESET(nRESET), .fe(fe), .RUN(RUN),
    .CRM_SEL(CRM_SEL), .CRM_ADR(CRM_ADR), .CRM_DIN(CRM_DIN), .CRM_WE(CRM_WE),
    .CRM_DOUT(CRM_DOUT), .ERR(ERR), .BUSY(BUSY)
  );

  // CRAM model: synchronous write, RD_LAT-cycle read pipeline
  logic [83:0] cram [2048];
  logic [83:0] rpipe [RD_LAT];
  logic        init_mem = 1'b1;
  logic [83:0] corrupt_mask = '0;

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 2048; i++) cram[i] <= '0;
    end else if (CRM_WE) begin
      cram[CRM_ADR] <= CRM_DIN ^ corrupt_mask;
    end
    rpipe[0] <= cram[CRM_ADR];
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign CRM_DOUT = rpipe[RD_LAT-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: "_o" is state before the pending op, "_n" after it
  logic [83:0] ref_mem [2048];
  logic [10:0] m_adr_o, m_adr_n;
  logic        m_err_o, m_err_n;
  logic [83:0] m_stg_o, m_stg_n;
  logic [35:0] m_rd_o,  m_rd_n;
  int          m_A, m_ack;
  bit          m_sel, m_we, pending, cmp_en;
  int          checks = 0, errors = 0;
  int          wr_log [$];
  bit          sel_seen;

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec bit i of the word (0 = MSB) lives at vector bit 83-i; chunks are right-justified
  function automatic logic [35:0] get_chunk(input logic [83:0] w, input int k);
    int s = 36 * k;
    int e = (s + 35 > 83) ? 83 : s + 35;
    logic [35:0] r = '0;
    for (int i = s; i <= e; i++) r[e-i] = w[83-i];
    return r;
  endfunction

  function automatic logic [83:0] put_chunk(input logic [83:0] w, input int k, input logic [35:0] d);
    int s = 36 * k;
    int e = (s + 35 > 83) ? 83 : s + 35;
    logic [83:0] r = w;
    for (int i = s; i <= e; i++) r[83-i] = d[e-i];
    return r;
  endfunction

  task automatic model_zero();
    m_adr_o = '0; m_adr_n = '0; m_err_o = 1'b0; m_err_n = 1'b0;
    m_stg_o = '0; m_stg_n = '0; m_rd_o = '0; m_rd_n = '0;
    pending = 1'b0; m_sel = 1'b0; m_we = 1'b0; m_A = 0; m_ack = 0;
  endtask

  // Load the model with one op accepted at the next edge; returns its latency
  task automatic model_op(input logic [2:0] f, input logic [35:0] d, output int lat);
    bit cram_op = (f >= 3'd4);
    bit viol    = cram_op && RUN;
    m_adr_o = m_adr_n; m_err_o = m_err_n; m_stg_o = m_stg_n; m_rd_o = m_rd_n;
    lat = 1;
    if (f == 3'd0) begin
      m_adr_n = d[10:0];
      m_err_n = 1'b0;
    end else if (f <= 3'd3) begin
      m_stg_n = put_chunk(m_stg_o, int'(f) - 1, d);
    end else if (viol) begin
      m_err_n = 1'b1;
    end else if (f == 3'd4) begin
      lat = COMMIT_LAT;
      ref_mem[m_adr_o] = m_stg_o ^ corrupt_mask;
      if (VERIFY && corrupt_mask != '0) m_err_n = 1'b1;
      m_adr_n = m_adr_o + 11'd1;
    end else begin
      lat = READ_LAT;
      m_rd_n = get_chunk(ref_mem[m_adr_o], int'(f) - 5);
    end
    m_sel   = cram_op && !viol;
    m_we    = (f == 3'd4) && !viol;
    m_A     = cyc + 1;
    m_ack   = m_A + lat - 1;
    pending = 1'b1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [35:0] d, output int lat_meas);
    int lat_model;
    @(negedge CLK);
    model_op(f, d, lat_model);
    fe.FE_REQ  = 1'b1;
    fe.FE_FUNC = f;
    fe.FE_DATA = d;
    lat_meas = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (fe.FE_ACK) begin
        lat_meas = n;
        break;
      end
    end
    fe.FE_REQ = 1'b0;
    if (lat_meas == 0) begin
      errors++;
      checks++;
      $display("FAIL ack_timeout actual=none expected=%0d func=%0d", lat_model, f);
    end
  endtask

  task automatic chk_wr(input string nm, input int exp);
    if (wr_log.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=no_write expected=%0d", nm, exp);
    end else begin
      chk(nm, 84'(wr_log.pop_front()), 84'(exp));
    end
  endtask

  // Per-cycle compare against the model, sampled 1ns after each rising edge
  initial begin
    int  c;
    bit  nw;
    forever begin
      @(posedge CLK);
      #1;
      if (cmp_en) begin
        c  = cyc;
        nw = !pending || (c >= m_ack);
        chk("FE_ACK",  84'(fe.FE_ACK), 84'(pending && c == m_ack));
        chk("BUSY",    84'(BUSY),      84'(pending && c >= m_A && c <= m_ack));
        chk("CRM_SEL", 84'(CRM_SEL),   84'(pending && m_sel && c >= m_A && c < m_ack));
        chk("CRM_WE",  84'(CRM_WE),    84'(pending && m_we && c == m_A));
        chk("CRM_ADR", 84'(CRM_ADR),   84'(nw ? m_adr_n : m_adr_o));
        chk("ERR",     84'(ERR),       84'(nw ? m_err_n : m_err_o));
        chk("CRM_DIN", CRM_DIN,        nw ? m_stg_n : m_stg_o);
        chk("FE_RDATA",84'(fe.FE_RDATA), 84'(nw ? m_rd_n : m_rd_o));
        if (CRM_WE)  wr_log.push_back(int'(CRM_ADR));
        if (CRM_SEL) sel_seen = 1'b1;
      end
    end
  end

  initial begin
    int lat;
    logic [2:0]  f;
    logic [35:0] d;
    fe.FE_REQ = 1'b0; fe.FE_FUNC = '0; fe.FE_DATA = '0;
    cmp_en = 1'b0;
    sel_seen = 1'b0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    model_zero();

    repeat (2) @(negedge CLK);
    init_mem = 1'b0;
    chk("rst_ack",  84'(fe.FE_ACK), 84'(0));
    chk("rst_busy", 84'(BUSY),      84'(0));
    chk("rst_sel",  84'(CRM_SEL),   84'(0));
    chk("rst_adr",  84'(CRM_ADR),   84'(0));
    nRESET = 1'b1;
    cmp_en = 1'b1;

    // Reset then ACK response
    issue(3'd0, 36'o1234, lat);
    chk("ladr_lat", 84'(lat), 84'(1));
    chk("ladr_adr", 84'(CRM_ADR), 84'(11'o1234));
    issue(3'd4, 36'o0, lat);
    chk("commit_lat", 84'(lat), 84'(COMMIT_LAT));
    chk_wr("commit_wadr", 11'o1234);

    // Full write / readback
    issue(3'd0, 36'o0100, lat);
    issue(3'd1, 36'o123456701234, lat);
    issue(3'd2, 36'o765432107654, lat);
    issue(3'd3, 36'o7777, lat);
    issue(3'd4, 36'o0, lat);
    chk_wr("wb_wadr", 11'o0100);
    chk("wb_adr_inc", 84'(CRM_ADR), 84'(11'o0101));
    issue(3'd0, 36'o0100, lat);
    issue(3'd5, 36'o0, lat);
    chk("rd_lat", 84'(lat), 84'(READ_LAT));
    chk("rd0", 84'(fe.FE_RDATA), 84'(36'o123456701234));
    issue(3'd6, 36'o0, lat);
    chk("rd1", 84'(fe.FE_RDATA), 84'(36'o765432107654));
    issue(3'd7, 36'o0, lat);
    chk("rd2", 84'(fe.FE_RDATA), 84'(36'o000000007777));
    chk("rd_noinc", 84'(CRM_ADR), 84'(11'o0100));

    // Address wrap
    issue(3'd0, 36'o3777, lat);
    issue(3'd4, 36'o0, lat);
    issue(3'd4, 36'o0, lat);
    chk_wr("wrap_w0", 2047);
    chk_wr("wrap_w1", 0);
    chk("wrap_adr", 84'(CRM_ADR), 84'(1));

    // RUN interlock
    @(negedge CLK);
    RUN = 1'b1;
    sel_seen = 1'b0;
    issue(3'd4, 36'o0, lat);
    chk("run_lat", 84'(lat), 84'(1));
    chk("run_err", 84'(ERR), 84'(1));
    chk("run_nosel", 84'(sel_seen), 84'(0));
    chk("run_nowr", 84'(wr_log.size()), 84'(0));
    RUN = 1'b0;
    issue(3'd0, 36'o0005, lat);
    chk("run_errclr", 84'(ERR), 84'(0));

    // Reset in the middle of a COMMIT (during WRITE)
    @(negedge CLK);
    model_op(3'd4, 36'o0, lat);
    ref_mem[m_adr_o] = cram[m_adr_o];
    fe.FE_REQ = 1'b1; fe.FE_FUNC = 3'd4; fe.FE_DATA = '0;
    @(negedge CLK);
    fe.FE_REQ = 1'b0;
    cmp_en = 1'b0;
    nRESET = 1'b0;
    #1;
    chk("mid_we",   84'(CRM_WE),      84'(0));
    chk("mid_sel",  84'(CRM_SEL),     84'(0));
    chk("mid_ack",  84'(fe.FE_ACK),   84'(0));
    chk("mid_busy", 84'(BUSY),        84'(0));
    chk("mid_adr",  84'(CRM_ADR),     84'(0));
    chk("mid_din",  CRM_DIN,          84'(0));
    chk("mid_rd",   84'(fe.FE_RDATA), 84'(0));
    chk("mid_err",  84'(ERR),         84'(0));
    model_zero();
    wr_log.delete();
    repeat (2) @(negedge CLK);
    nRESET = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid_nowr", 84'(wr_log.size()), 84'(0));

`ifdef CRM_LOADER_VERIFY_EN
    // Verify catches a corrupted write (spec bit 40)
    issue(3'd0, 36'o0200, lat);
    issue(3'd2, 36'o0, lat);
    corrupt_mask = 84'(1) << (83 - 40);
    issue(3'd4, 36'o0, lat);
    corrupt_mask = '0;
    chk("vfy_lat", 84'(lat), 84'(3 + RD_LAT));
    chk("vfy_err", 84'(ERR), 84'(1));
    issue(3'd0, 36'o0200, lat);
`endif

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      f = 3'($urandom_range(0, 7));
      d = {4'($urandom), 32'($urandom)};
      if (f == 3'd0 && $urandom_range(0, 3) == 0) d[10:0] = 11'h7FF - 11'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      @(negedge CLK);
      RUN = ($urandom_range(0, 9) == 0);
      issue(f, d, lat);
    end
    @(negedge CLK);
    RUN = 1'b0;
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
